board_input_debouncer: RTL and testbench

//   Input-side conditioner for the DE10-Lite switches and push-buttons.

---
 rtl/board_input_debouncer.sv | 191 +++++++++++++++++++
 tb/tb_board_input_debouncer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_input_debouncer.sv
// board_input_debouncer
//   Input conditioner for the DE10-Lite slide switches and push-buttons.
//   Every raw line gets a 2-FF synchroniser and an independent debounce
//   counter; clean levels and one-cycle edge pulses are presented to the
//   consuming LED/display blocks. KEY lines are active-low on the board and
//   are inverted after synchronisation, so all KEY outputs read 1 = pressed.
//   Optional feature macro: KEY_REPEAT_EN adds per-key auto-repeat of
//   KEY_PRESS_PULSE while a key is held.
module board_input_debouncer #(
  parameter int NUM_SW          = 10,
  parameter int NUM_KEY         = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic               MAX10_CLK1_50,
  input  logic               RST,
  input  logic [NUM_SW-1:0]  SW,
  input  logic [NUM_KEY-1:0] KEY,
  output logic [NUM_SW-1:0]  SW_CLEAN,
  output logic [NUM_SW-1:0]  SW_CHANGED,
  output logic [NUM_KEY-1:0] KEY_PRESSED,
  output logic [NUM_KEY-1:0] KEY_PRESS_PULSE,
  output logic [NUM_KEY-1:0] KEY_RELEASE_PULSE
);

  // Switch and key lines share one debounce datapath: SW in the low bits,
  // (inverted) KEY in the high bits.
  localparam int NUM_LINE = NUM_SW + NUM_KEY;
  localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // A one-cycle debounce window could pulse on consecutive cycles, and the
  // repeat timer is sized from REPEAT_DELAY, so the period must fit in it.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
    $error("REPEAT_DELAY must be >= 2 and REPEAT_PERIOD in 1..REPEAT_DELAY");
  end

  logic [NUM_SW-1:0]   r_sw_meta;
  logic [NUM_SW-1:0]   r_sw_sync;
  logic [NUM_KEY-1:0]  r_key_meta;
  logic [NUM_KEY-1:0]  r_key_sync;
  logic [NUM_LINE-1:0] w_line_sync;
  logic [NUM_LINE-1:0] r_line_stable;
  logic [NUM_LINE-1:0] r_line_rise;
  logic [NUM_LINE-1:0] r_line_fall;
  logic [CNT_W-1:0]    r_line_cnt [NUM_LINE];
  logic [NUM_KEY-1:0]  w_key_press;

  // Two-flop synchronisers; KEY flops idle at 1 so reset looks like "released".
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_key_meta <= '1;
      r_key_sync <= '1;
    end else begin
      r_sw_meta  <= SW;
      r_sw_sync  <= r_sw_meta;
      r_key_meta <= KEY;
      r_key_sync <= r_key_meta;
    end
  end

  assign w_line_sync = {~r_key_sync, r_sw_sync};

  // Per-line debounce: a change is accepted only after DEBOUNCE_CYCLES
  // consecutive samples disagree with the stable level; any bounce back
  // restarts the count. Edge pulses are registered with the new level.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      r_line_stable <= '0;
      r_line_rise   <= '0;
      r_line_fall   <= '0;
      for (int i = 0; i < NUM_LINE; i++) begin
        r_line_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LINE; i++) begin
        r_line_rise[i] <= 1'b0;
        r_line_fall[i] <= 1'b0;
        if (w_line_sync[i] == r_line_stable[i]) begin
          r_line_cnt[i] <= '0;
        end else if (r_line_cnt[i] < CNT_LAST) begin
          r_line_cnt[i] <= r_line_cnt[i] + CNT_W'(1);
        end else begin
          r_line_stable[i] <= w_line_sync[i];
          r_line_cnt[i]    <= '0;
          r_line_rise[i]   <= w_line_sync[i];
          r_line_fall[i]   <= ~w_line_sync[i];
        end
      end
    end
  end

  assign SW_CLEAN          = r_line_stable[NUM_SW-1:0];
  assign SW_CHANGED        = r_line_rise[NUM_SW-1:0] | r_line_fall[NUM_SW-1:0];
  assign KEY_PRESSED       = r_line_stable[NUM_LINE-1:NUM_SW];
  assign KEY_RELEASE_PULSE = r_line_fall[NUM_LINE-1:NUM_SW];
  assign w_key_press       = r_line_rise[NUM_LINE-1:NUM_SW];

`ifdef KEY_REPEAT_EN
  // state      | meaning
  // RPT_IDLE   | key released, waiting for an accepted press
  // RPT_HOLD   | key held, timing the initial REPEAT_DELAY
  // RPT_REPEAT | key held, emitting a pulse every REPEAT_PERIOD
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HOLD   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  localparam int TMR_W = $clog2(REPEAT_DELAY);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  logic [NUM_KEY-1:0] w_rpt_pulse;

  for (genvar k = 0; k < NUM_KEY; k++) begin : g_rpt
    rpt_state_t       r_state;
    rpt_state_t       w_state_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_nxt;
    logic             w_pulse;

    // Repeat FSM state and timer registers.
    always_ff @(posedge MAX10_CLK1_50) begin
      if (RST) begin
        r_state <= RPT_IDLE;
        r_tmr   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_tmr   <= w_tmr_nxt;
      end
    end

    // Next state and repeat pulse; a release in the same cycle wins over a
    // timer expiry so no stray pulse follows the release.
    always_comb begin
      w_state_nxt = r_state;
      w_tmr_nxt   = r_tmr;
      w_pulse     = 1'b0;
      case (r_state)
        RPT_IDLE: begin
          if (w_key_press[k]) begin
            w_state_nxt = RPT_HOLD;
            w_tmr_nxt   = '0;
          end
        end
        RPT_HOLD: begin
          if (KEY_RELEASE_PULSE[k]) begin
            w_state_nxt = RPT_IDLE;
            w_tmr_nxt   = '0;
          end else if (r_tmr == DELAY_LAST) begin
            w_pulse     = 1'b1;
            w_state_nxt = RPT_REPEAT;
            w_tmr_nxt   = '0;
          end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (KEY_RELEASE_PULSE[k]) begin
            w_state_nxt = RPT_IDLE;
            w_tmr_nxt   = '0;
          end else if (r_tmr == PERIOD_LAST) begin
            w_pulse   = 1'b1;
            w_tmr_nxt = '0;
          end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end
        end
        default: begin
          w_state_nxt = RPT_IDLE;
          w_tmr_nxt   = '0;
        end
      endcase
    end

    assign w_rpt_pulse[k] = w_pulse;
  end

  assign KEY_PRESS_PULSE = w_key_press | w_rpt_pulse;
`else
  assign KEY_PRESS_PULSE = w_key_press;
`endif

endmodule

// File: tb/tb_board_input_debouncer.sv
// Testbench for board_input_debouncer with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=3. Expected output words are queued as each
// scenario is driven and popped one per clock when the DUT output is sampled.
module tb_board_input_debouncer;

  localparam int NUM_SW  = 10;
  localparam int NUM_KEY = 2;
  localparam int DEB     = 4;
  localparam int RDLY    = 8;
  localparam int RPER    = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_SW-1:0]  sw;
  logic [NUM_KEY-1:0] key;
  logic [NUM_SW-1:0]  sw_clean;
  logic [NUM_SW-1:0]  sw_changed;
  logic [NUM_KEY-1:0] key_pressed;
  logic [NUM_KEY-1:0] key_press_pulse;
  logic [NUM_KEY-1:0] key_release_pulse;
  logic [25:0]        obs;

  logic [25:0] exp_q [$];
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  board_input_debouncer #(
    .NUM_SW          (NUM_SW),
    .NUM_KEY         (NUM_KEY),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER)
  ) u_dut (
    .MAX10_CLK1_50     (clk),
    .RST               (rst),
    .SW                (sw),
    .KEY               (key),
    .SW_CLEAN          (sw_clean),
    .SW_CHANGED        (sw_changed),
    .KEY_PRESSED       (key_pressed),
    .KEY_PRESS_PULSE   (key_press_pulse),
    .KEY_RELEASE_PULSE (key_release_pulse)
  );

  assign obs = {sw_clean, sw_changed, key_pressed, key_press_pulse, key_release_pulse};

  function automatic logic [25:0] mk(input logic [9:0] sc, input logic [9:0] sch,
                                     input logic [1:0] kp, input logic [1:0] kpp,
                                     input logic [1:0] krp);
    return {sc, sch, kp, kpp, krp};
  endfunction

  task automatic test_reset();
    logic [25:0] e;
    rst = 1'b1;
    sw  = '0;
    key = 2'b11;
    exp_q.push_back(mk('0, '0, '0, '0, '0));
    repeat (2) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want %h", obs, e);
    end
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) exp_q.push_back(mk('0, '0, '0, '0, '0));
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: got %h want %h", c, obs, e);
      end
    end
  endtask

  task automatic test_sw_change();
    logic [9:0]  sc, sch;
    logic [25:0] e;
    for (int p = 0; p < 2; p++) begin
      sw[3] = (p == 0);
      for (int c = 1; c <= 10; c++) begin
        sc = '0; sch = '0;
        sc[3]  = (p == 0) ? (c >= 6) : (c < 6);
        sch[3] = (c == 6);
        exp_q.push_back(mk(sc, sch, '0, '0, '0));
      end
      for (int c = 1; c <= 10; c++) begin
        @(posedge clk); #1;
        e = exp_q.pop_front();
        vectors++;
        if (obs !== e) begin
          miscompares++;
          $display("FAIL sw_change phase %0d cyc %0d: got %h want %h", p, c, obs, e);
        end
      end
    end
  endtask

  task automatic test_sw_glitch();
    logic [9:0]  sc, sch;
    logic [25:0] e;
    // width 3 must be rejected, width 4 (== DEBOUNCE_CYCLES) accepted
    for (int w = 3; w <= 4; w++) begin
      sw[5] = 1'b1;
      for (int c = 1; c <= 14; c++) begin
        sc = '0; sch = '0;
        if (w == 4) begin
          sc[5]  = (c >= 6) && (c < 10);
          sch[5] = (c == 6) || (c == 10);
        end
        exp_q.push_back(mk(sc, sch, '0, '0, '0));
      end
      for (int c = 1; c <= 14; c++) begin
        @(posedge clk); #1;
        e = exp_q.pop_front();
        vectors++;
        if (obs !== e) begin
          miscompares++;
          $display("FAIL sw_glitch width %0d cyc %0d: got %h want %h", w, c, obs, e);
        end
        if (c == w) sw[5] = 1'b0;
      end
    end
  endtask

  task automatic test_key_bounce();
    logic [1:0]  kp, kpp, krp;
    logic [25:0] e;
    key[0] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      kp = '0; kpp = '0;
      kp[0]  = (c >= 9);
      kpp[0] = (c == 9);
      exp_q.push_back(mk('0, '0, kp, kpp, '0));
    end
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL key_bounce_press cyc %0d: got %h want %h", c, obs, e);
      end
      if (c == 2) key[0] = 1'b1;
      if (c == 3) key[0] = 1'b0;
    end
    key[0] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      kp = '0; krp = '0;
      kp[0]  = (c < 6);
      krp[0] = (c == 6);
      exp_q.push_back(mk('0, '0, kp, '0, krp));
    end
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL key_bounce_release cyc %0d: got %h want %h", c, obs, e);
      end
    end
  endtask

  // Release is accepted exactly when the first repeat would be due, so the
  // repeat build must suppress it as well.
  task automatic test_simultaneous();
    logic [9:0]  sc, sch;
    logic [1:0]  kp, kpp, krp;
    logic [25:0] e;
    for (int p = 0; p < 2; p++) begin
      key[1] = (p == 1);
      sw[0]  = (p == 0);
      for (int c = 1; c <= 8; c++) begin
        sc = '0; sch = '0; kp = '0; kpp = '0; krp = '0;
        sc[0]  = (p == 0) ? (c >= 6) : (c < 6);
        kp[1]  = sc[0];
        sch[0] = (c == 6);
        kpp[1] = (p == 0) && (c == 6);
        krp[1] = (p == 1) && (c == 6);
        exp_q.push_back(mk(sc, sch, kp, kpp, krp));
      end
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk); #1;
        e = exp_q.pop_front();
        vectors++;
        if (obs !== e) begin
          miscompares++;
          $display("FAIL simultaneous phase %0d cyc %0d: got %h want %h", p, c, obs, e);
        end
      end
    end
  endtask

  task automatic test_reset_pending();
    logic [9:0]  sc, sch;
    logic [1:0]  kp, kpp, krp;
    logic [25:0] e;
    sw[7]  = 1'b1;
    key[0] = 1'b0;
    // reset at edges 4-5 discards the pending change; it restarts afterwards
    for (int c = 1; c <= 12; c++) begin
      sc = '0; sch = '0; kp = '0; kpp = '0;
      sc[7]  = (c >= 11);
      sch[7] = (c == 11);
      kp[0]  = (c >= 11);
      kpp[0] = (c == 11);
      exp_q.push_back(mk(sc, sch, kp, kpp, '0));
    end
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset_pending cyc %0d: got %h want %h", c, obs, e);
      end
      if (c == 3) rst = 1'b1;
      if (c == 5) rst = 1'b0;
    end
    sw[7]  = 1'b0;
    key[0] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      sc = '0; sch = '0; kp = '0; krp = '0;
      sc[7]  = (c < 6);
      sch[7] = (c == 6);
      kp[0]  = (c < 6);
      krp[0] = (c == 6);
      exp_q.push_back(mk(sc, sch, kp, '0, krp));
    end
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset_pending_release cyc %0d: got %h want %h", c, obs, e);
      end
    end
  endtask

  task automatic test_repeat();
    logic [1:0]  kp, kpp, krp;
    logic [25:0] e;
    int          acc, rel;
    acc = 2 + DEB;
    rel = 36 + 2 + DEB;
    key[0] = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      kp = '0; kpp = '0; krp = '0;
      kp[0]  = (c >= acc) && (c < rel);
      krp[0] = (c == rel);
      kpp[0] = (c == acc);
`ifdef KEY_REPEAT_EN
      if ((c >= acc + RDLY) && (c < rel) && (((c - acc - RDLY) % RPER) == 0))
        kpp[0] = 1'b1;
`endif
      exp_q.push_back(mk('0, '0, kp, kpp, krp));
    end
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL repeat cyc %0d: got %h want %h", c, obs, e);
      end
      if (c == 36) key[0] = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sw_change();
    test_sw_glitch();
    test_key_bounce();
    test_simultaneous();
    test_reset_pending();
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
